// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 channel selector with valid tracking, stall (hold) and flush (bubble).
// Out-of-range selects fall back to channel 0 and raise a registered error flag.
module mux_nto1_pipe #(
  parameter int WIDTH          = 32,
  parameter int CH             = 4,
  parameter int SEL_W          = 2,
  parameter int ZERO_ON_BUBBLE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CH*WIDTH-1:0]   data_i,
  input  logic [SEL_W-1:0]      select_i,
  input  logic                  valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  valid_o,
  output logic [SEL_W-1:0]      select_o,
  output logic                  sel_err_o
);

  generate
    if (CH < 2 || CH > 16 || (1 << SEL_W) < CH) begin : g_bad_params
      $error("mux_nto1_pipe: CH must be 2..16 and 2**SEL_W must cover CH");
    end
  endgenerate

  logic [WIDTH-1:0] sel_data;
  logic             err_n;

  // Compare against every legal code instead of indexing, so unused codes never yield X.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    sel_data = data_i[WIDTH-1:0];
    err_n    = 1'b1;
    for (int k = 0; k < CH; k++) begin
      if (select_i == SEL_W'(k)) begin
        sel_data = data_i[k*WIDTH +: WIDTH];
        err_n    = 1'b0;
      end
    end
  end

  // Flush beats stall; a non-stalled edge either loads a valid item or drops a bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments keep register updates order-independent.
    if (rst_i) begin
      data_o    <= '0;
      valid_o   <= 1'b0;
      select_o  <= '0;
      sel_err_o <= 1'b0;
    end else if (flush_i || !stall_i) begin
      if (flush_i || !valid_i) begin
        valid_o   <= 1'b0;
        select_o  <= '0;
        sel_err_o <= 1'b0;
        if (ZERO_ON_BUBBLE != 0) data_o <= '0;
      end else begin
        data_o    <= sel_data;
        valid_o   <= 1'b1;
        select_o  <= select_i;
        sel_err_o <= err_n;
      end
    end
  end

endmodule

// File: doc/mux_nto1_pipe.md
Name: mux_nto1_pipe

Overview:
- Parametrised, registered N-to-1 selector for the pipelined CPU datapath. It generalises the combinational 4-input select muxes to CH channels of WIDTH bits.
- Adds a registered output stage with valid tracking, stall (hold) and flush (bubble).
- Flags out-of-range selects.
- Used at pipeline boundaries, e.g. EX-stage operand forwarding feeding the EX/MEM register.

Parameters:
- WIDTH, 32, bit width of each data channel.
- CH, 4, number of input channels; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2^SEL_W >= CH.
- ZERO_ON_BUBBLE, 1, 1 = data_o forced to 0 when a bubble is loaded; 0 = data_o keeps its previous value.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- data_i  input  CH*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- select_i  input  SEL_W  channel select.
- valid_i  input  1  current inputs are meaningful.
- stall_i  input  1  hold all output registers.
- flush_i  input  1  load a bubble.
- data_o  output  WIDTH  registered selected data.
- valid_o  output  1  registered valid.
- select_o  output  SEL_W  registered select actually applied; used for debug and forwarding checks.
- sel_err_o  output  1  registered flag: the loaded select was out of range.

Behaviour:
- Reset (rst_i=1, asynchronous, immediate, no clock needed):
  - data_o=0, valid_o=0, select_o=0, sel_err_o=0.
  - Reset asserted mid-operation overrides everything; outputs stay 0 until the first rising edge after rst_i falls.
- Combinational select path:
  - sel_data = channel[select_i] when select_i < CH.
  - Otherwise sel_data = channel 0 and err_n = 1.
  - No X propagation from unused select codes.
- Register update priority on each rising edge with rst_i=0, highest first:
  1. flush_i=1: valid_o<=0, sel_err_o<=0, select_o<=0; data_o<=0 if ZERO_ON_BUBBLE=1, else data_o holds. Flush wins over stall.
  2. stall_i=1: all outputs hold their values.
  3. valid_i=1: data_o<=sel_data, select_o<=select_i, sel_err_o<=err_n, valid_o<=1.
  4. valid_i=0 (bubble): valid_o<=0, sel_err_o<=0, select_o<=0; data_o<=0 if ZERO_ON_BUBBLE=1, else data_o holds.
- Latency:
  - Exactly 1 cycle from inputs to outputs when not stalled.
  - Throughput of 1 item per cycle.
- Stall duration: no limit on consecutive stall cycles; the output is stable for the whole stall.
- Out-of-range select:
  - Still produces valid_o=1 (when valid_i=1) with channel-0 data and sel_err_o=1.
  - select_o records the raw select_i value.
- State: implicit two-state pipeline slot, EMPTY (valid_o=0) and FULL (valid_o=1).
  - EMPTY->FULL on load with valid_i=1.
  - FULL->EMPTY on flush, or on a non-stalled edge with valid_i=0.
  - Any state holds under stall without flush.
- Input sensitivity: data_i and select_i changes while stalled have no effect on outputs.
- Elaboration check: parameter violations (2^SEL_W < CH, CH < 2) are an elaboration error; implement with a generate-time check.

Test Plan:
- Reset then basic load: rst_i pulse; CH=4, WIDTH=32, channels {0x11,0x22,0x33,0x44}, select_i=2, valid_i=1, one edge -> data_o=0x33, valid_o=1, select_o=2, sel_err_o=0.
- Sweep and latency: select_i=0,1,2,3 on consecutive cycles -> data_o=0x11,0x22,0x33,0x44 exactly one cycle later each; no gaps.
- Stall then flush:
  - Load 0x44, then stall_i=1 for 3 cycles with select_i changing -> data_o stays 0x44, valid_o=1.
  - Then flush_i=1 with stall_i=1 -> valid_o=0, and data_o=0 (ZERO_ON_BUBBLE=1) or 0x44 (=0).
- Out-of-range select: CH=5, SEL_W=3, select_i=7, valid_i=1 -> data_o=channel0, sel_err_o=1, select_o=7; next cycle with a legal select clears sel_err_o.
- Bubble: valid_i=0 on a non-stalled edge -> valid_o=0, sel_err_o=0, data_o per ZERO_ON_BUBBLE; then valid_i=1 with select_i=1 -> valid_o=1, data_o=0x22.
- Asynchronous reset mid-stream: assert rst_i between clock edges while valid_o=1 -> all outputs 0 immediately, before the next edge; release, then load resumes normally.
